execution_block: RTL and testbench
==================================

// Module: execution_block
// PURPOSE
//  EX stage of the 8-bit MIPS-style pipeline: combinational ALU on A/B selected by Op_ex, results and flags registered on Clk3.
//  Also registers the decode-stage memory controls and destination register to the MEM stage; latency one cycle.
// PARAMETERS
//  DATA_W  8  operand/result width (all behaviour below is specified at 8)
//  OP_W    5  opcode width
//  RW_W    5  destination-register index width
// PORTS
//  Clk3             in   1      pipeline clock, rising edge
//  Rst_n            in   1      asynchronous active-low reset
//  A                in   8      operand A (rs)
//  B                in   8      operand B (rt / shift amount)
//  data_in          in   8      immediate / load data from decode
//  Op_ex            in   5      ALU opcode
//  Mem_en_dec       in   1      memory enable from decode
//  Mem_rw_dec       in   1      memory read(0)/write(1) from decode
//  Mem_mux_sel_dec  in   1      writeback mux select from decode
//  Rw_dec           in   5      destination register from decode
//  ans_ex           out  8      registered ALU result
//  Flag             out  4      registered flags {C,Z,N,V} = Flag[3:0]
//  Data_out         out  8      registered data_in
//  B_bypass         out  8      registered B (store data)
//  Mem_en_ex, Mem_rw_ex, Mem_mux_sel_ex  out 1 each  registered copies of *_dec
//  Rw_ex            out  5      registered Rw_dec
// BEHAVIOUR
//  - Reset: Rst_n=0 forces every output to 0 immediately, independent of Clk3.
//  - Every output register loads on every rising Clk3; no stall or enable; latency exactly 1.
//  - Opcodes: 00000 ADD A+B | 00001 ADC A+B+C | 00010 SUB A-B | 00011 SBB A-B-C
//    00100 AND | 00101 OR | 00110 XOR | 00111 NOT A | 01000 NEG -A
//    01001 CMP (A-B, flags only) | 01010 MOV A | 01011 MOVB B
//    01100 NAND | 01101 NOR | 01110 XNOR | 01111 INC A+1
//    10000 DEC A-1 | 10001 CLR 0 | 10100 SHL A<<B[2:0] | 10101 SHR A>>B[2:0]
//    10110 ROL A by B[2:0] | 10111 ROR A by B[2:0] | 11000 ASR A>>>B[2:0]
//    11001 LD / 11010 ST: ans=A+B (effective address), flags hold
//    11011 MUL (optional) | 11100 LDI: ans=data_in | 11101 SWAP nibbles of A
//    10010, 10011, 11110, 11111: NOP (ans and Flag hold)
//  - C: carry-out of add, borrow of sub (1 when A<B unsigned), last bit shifted out for shifts/rotates; 0 for logic ops.
//  - Z: 8-bit result==0. N: result[7]. V: signed overflow for add/sub/inc/dec/neg, else 0.
//  - CMP, LD, ST, NOP: ans_ex holds. CMP updates flags; LD, ST, NOP hold flags. All other opcodes update ans_ex and all four flags.
//  - Shift amount 0: result=A, C=0. Arithmetic wraps modulo 256.
//  - Pass-through regs (Data_out, B_bypass, Mem_*_ex, Rw_ex) never depend on Op_ex.
// CONFIGURATION
//  EXEC_MUL_EN defined: 11011 MUL, ans=(A*B)[7:0], C=|(A*B)[15:8], Z/N from result, V=0.
//  Undefined: 11011 is a NOP; no multiplier inferred.
// STRUCTURE
//  exec_pkg: opcode localparams, flag bit indices (FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0).
//  Sub-module exec_alu: combinational {A,B,data_in,Op_ex,C_in} -> {result, flags, upd_ans, upd_flag}.
//  Top: pipeline registers with async reset.
// TESTING
//  1. Rst_n=0 mid-cycle with outputs nonzero -> all outputs 0 at once; stay 0 until Rst_n=1 and next edge.
//  2. MOV A=1,2,3,4, Rw_dec=8,6,0,4 -> ans_ex 1,2,3,4 and Rw_ex 8,6,0,4 one cycle later; Z=0.
//  3. ADD A=3,B=3 -> 6. ADD A=0xC0,B=0x40 -> 0x00, C=1, Z=1. SUB 0x40-0xC0 -> 0x80, C=1, N=1, V=1.
//  4. CMP A=2,B=2 -> Z=1, ans_ex unchanged. NOP 11111 -> ans_ex and Flag unchanged.
//  5. SHR A=0x80,B=4 -> 0x08. ROL A=0xC0,B=1 -> 0x81, C=1. CLR -> 0, Z=1.
//  6. ST A=0xC0,B=1,data_in=8,Mem_*=1,Rw_dec=10 -> ans_ex 0xC1, Data_out 8, B_bypass 1, Mem_*_ex 1, Rw_ex 10.
//     MUL 0x10*0x10 -> 0x00, C=1 with EXEC_MUL_EN; NOP without it.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared widths, opcode encodings, flag bit positions and ALU payload for the EX stage.
// EXEC_MUL_EN (when defined) turns opcode OP_MUL into an 8x8 multiply.
package exec_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned OP_W   = 5;
   localparam int unsigned RW_W   = 5;
   localparam int unsigned FLAG_W = 4;

   localparam int unsigned FLAG_C = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_V = 0;

   localparam logic [OP_W-1:0] OP_ADD  = 5'b00000;
   localparam logic [OP_W-1:0] OP_ADC  = 5'b00001;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00010;
   localparam logic [OP_W-1:0] OP_SBB  = 5'b00011;
   localparam logic [OP_W-1:0] OP_AND  = 5'b00100;
   localparam logic [OP_W-1:0] OP_OR   = 5'b00101;
   localparam logic [OP_W-1:0] OP_XOR  = 5'b00110;
   localparam logic [OP_W-1:0] OP_NOT  = 5'b00111;
   localparam logic [OP_W-1:0] OP_NEG  = 5'b01000;
   localparam logic [OP_W-1:0] OP_CMP  = 5'b01001;
   localparam logic [OP_W-1:0] OP_MOV  = 5'b01010;
   localparam logic [OP_W-1:0] OP_MOVB = 5'b01011;
   localparam logic [OP_W-1:0] OP_NAND = 5'b01100;
   localparam logic [OP_W-1:0] OP_NOR  = 5'b01101;
   localparam logic [OP_W-1:0] OP_XNOR = 5'b01110;
   localparam logic [OP_W-1:0] OP_INC  = 5'b01111;
   localparam logic [OP_W-1:0] OP_DEC  = 5'b10000;
   localparam logic [OP_W-1:0] OP_CLR  = 5'b10001;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b10100;
   localparam logic [OP_W-1:0] OP_SHR  = 5'b10101;
   localparam logic [OP_W-1:0] OP_ROL  = 5'b10110;
   localparam logic [OP_W-1:0] OP_ROR  = 5'b10111;
   localparam logic [OP_W-1:0] OP_ASR  = 5'b11000;
   localparam logic [OP_W-1:0] OP_LD   = 5'b11001;
   localparam logic [OP_W-1:0] OP_ST   = 5'b11010;
   localparam logic [OP_W-1:0] OP_MUL  = 5'b11011;
   localparam logic [OP_W-1:0] OP_LDI  = 5'b11100;
   localparam logic [OP_W-1:0] OP_SWAP = 5'b11101;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [FLAG_W-1:0] flags;
      logic              upd_ans;
      logic              upd_flag;
   } alu_out_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational EX-stage ALU: result, {C,Z,N,V} and which of ans/flags the opcode updates.
// EXEC_MUL_EN selects whether OP_MUL multiplies or behaves as a NOP.
module exec_alu
   import exec_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [OP_W-1:0]   op_i,
   input  logic              c_i,
   output alu_out_t          alu_c_o
);

   logic [DATA_W:0]     sum9;
   logic [2*DATA_W-1:0] sh16;
   logic [DATA_W-1:0]   res;
   logic [2:0]          shamt;
   logic                cf;
   logic                vf;
   logic                upd_a;
   logic                upd_f;
`ifdef EXEC_MUL_EN
   logic [2*DATA_W-1:0] prod;
`endif

   assign shamt = b_i[2:0];

   // Shifts/rotates run through a double-width window so the last bit out lands at a fixed index.
   always_comb begin
      sum9  = '0;
      sh16  = '0;
      res   = '0;
      cf    = 1'b0;
      vf    = 1'b0;
      upd_a = 1'b1;
      upd_f = 1'b1;
`ifdef EXEC_MUL_EN
      prod  = '0;
`endif
      case (op_i)
         OP_ADD, OP_ADC: begin
            sum9 = {1'b0, a_i} + {1'b0, b_i} + ((op_i == OP_ADC) ? 9'(c_i) : 9'd0);
            res  = sum9[DATA_W-1:0];
            cf   = sum9[DATA_W];
            vf   = (a_i[7] == b_i[7]) && (res[7] != a_i[7]);
         end
         OP_SUB, OP_SBB, OP_CMP: begin
            sum9  = {1'b0, a_i} - {1'b0, b_i} - ((op_i == OP_SBB) ? 9'(c_i) : 9'd0);
            res   = sum9[DATA_W-1:0];
            cf    = sum9[DATA_W];
            vf    = (a_i[7] != b_i[7]) && (res[7] != a_i[7]);
            upd_a = (op_i != OP_CMP);
         end
         OP_NEG: begin
            sum9 = 9'd0 - {1'b0, a_i};
            res  = sum9[DATA_W-1:0];
            cf   = sum9[DATA_W];
            vf   = (a_i == 8'h80);
         end
         OP_INC: begin
            sum9 = {1'b0, a_i} + 9'd1;
            res  = sum9[DATA_W-1:0];
            cf   = sum9[DATA_W];
            vf   = (a_i == 8'h7F);
         end
         OP_DEC: begin
            sum9 = {1'b0, a_i} - 9'd1;
            res  = sum9[DATA_W-1:0];
            cf   = sum9[DATA_W];
            vf   = (a_i == 8'h80);
         end
         OP_AND:  res = a_i & b_i;
         OP_OR:   res = a_i | b_i;
         OP_XOR:  res = a_i ^ b_i;
         OP_NOT:  res = ~a_i;
         OP_MOV:  res = a_i;
         OP_MOVB: res = b_i;
         OP_NAND: res = ~(a_i & b_i);
         OP_NOR:  res = ~(a_i | b_i);
         OP_XNOR: res = ~(a_i ^ b_i);
         OP_CLR:  res = '0;
         OP_SHL: begin
            sh16 = {8'h00, a_i} << shamt;
            res  = sh16[DATA_W-1:0];
            cf   = sh16[DATA_W];
         end
         OP_SHR: begin
            sh16 = {a_i, 8'h00} >> shamt;
            res  = sh16[2*DATA_W-1:DATA_W];
            cf   = sh16[DATA_W-1];
         end
         OP_ASR: begin
            sh16 = 16'($signed({a_i, 8'h00}) >>> shamt);
            res  = sh16[2*DATA_W-1:DATA_W];
            cf   = sh16[DATA_W-1];
         end
         OP_ROL: begin
            sh16 = {a_i, a_i} << shamt;
            res  = sh16[2*DATA_W-1:DATA_W];
            cf   = (shamt != 3'd0) && res[0];
         end
         OP_ROR: begin
            sh16 = {a_i, a_i} >> shamt;
            res  = sh16[DATA_W-1:0];
            cf   = (shamt != 3'd0) && res[7];
         end
         OP_LD, OP_ST: begin
            sum9  = {1'b0, a_i} + {1'b0, b_i};
            res   = sum9[DATA_W-1:0];
            upd_f = 1'b0;
         end
`ifdef EXEC_MUL_EN
         OP_MUL: begin
            prod = 16'(a_i) * 16'(b_i);
            res  = prod[DATA_W-1:0];
            cf   = |prod[2*DATA_W-1:DATA_W];
         end
`endif
         OP_LDI:  res = data_i;
         OP_SWAP: res = {a_i[3:0], a_i[7:4]};
         default: begin
            upd_a = 1'b0;
            upd_f = 1'b0;
         end
      endcase
   end

   always_comb begin
      alu_c_o                = '0;
      alu_c_o.result         = res;
      alu_c_o.flags[FLAG_C]  = cf;
      alu_c_o.flags[FLAG_Z]  = (res == '0);
      alu_c_o.flags[FLAG_N]  = res[7];
      alu_c_o.flags[FLAG_V]  = vf;
      alu_c_o.upd_ans        = upd_a;
      alu_c_o.upd_flag       = upd_f;
   end

endmodule

// File: rtl/execution_block.sv
// EX stage of the 8-bit pipeline: ALU result/flags plus MEM-stage controls, all registered on Clk3.
// Build with EXEC_MUL_EN defined to enable the multiply opcode.
module execution_block
   import exec_pkg::*;
(
   input  logic              Clk3,
   input  logic              Rst_n,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [DATA_W-1:0] data_in,
   input  logic [OP_W-1:0]   Op_ex,
   input  logic              Mem_en_dec,
   input  logic              Mem_rw_dec,
   input  logic              Mem_mux_sel_dec,
   input  logic [RW_W-1:0]   Rw_dec,
   output logic [DATA_W-1:0] ans_ex,
   output logic [FLAG_W-1:0] Flag,
   output logic [DATA_W-1:0] Data_out,
   output logic [DATA_W-1:0] B_bypass,
   output logic              Mem_en_ex,
   output logic              Mem_rw_ex,
   output logic              Mem_mux_sel_ex,
   output logic [RW_W-1:0]   Rw_ex
);

   alu_out_t          alu_c;
   logic [DATA_W-1:0] ans_d, ans_q;
   logic [FLAG_W-1:0] flag_d, flag_q;
   logic [DATA_W-1:0] data_q, bbyp_q;
   logic              mem_en_q, mem_rw_q, mem_sel_q;
   logic [RW_W-1:0]   rw_q;

   exec_alu u_alu (
      .a_i     (A),
      .b_i     (B),
      .data_i  (data_in),
      .op_i    (Op_ex),
      .c_i     (flag_q[FLAG_C]),
      .alu_c_o (alu_c)
   );

   // CMP/LD/ST/NOP keep the previous result and/or flags.
   always_comb begin
      ans_d  = alu_c.upd_ans  ? alu_c.result : ans_q;
      flag_d = alu_c.upd_flag ? alu_c.flags  : flag_q;
   end

   always_ff @(posedge Clk3 or negedge Rst_n) begin
      if (!Rst_n) begin
         ans_q     <= '0;
         flag_q    <= '0;
         data_q    <= '0;
         bbyp_q    <= '0;
         mem_en_q  <= 1'b0;
         mem_rw_q  <= 1'b0;
         mem_sel_q <= 1'b0;
         rw_q      <= '0;
      end else begin
         ans_q     <= ans_d;
         flag_q    <= flag_d;
         data_q    <= data_in;
         bbyp_q    <= B;
         mem_en_q  <= Mem_en_dec;
         mem_rw_q  <= Mem_rw_dec;
         mem_sel_q <= Mem_mux_sel_dec;
         rw_q      <= Rw_dec;
      end
   end

   assign ans_ex         = ans_q;
   assign Flag           = flag_q;
   assign Data_out       = data_q;
   assign B_bypass       = bbyp_q;
   assign Mem_en_ex      = mem_en_q;
   assign Mem_rw_ex      = mem_rw_q;
   assign Mem_mux_sel_ex = mem_sel_q;
   assign Rw_ex          = rw_q;

endmodule

// File: tb/tb_execution_block.sv
// Bench for execution_block: directed vector table, reset sequences, then random ops vs a reference model.
// Define EXEC_MUL_EN for both bench and RTL to exercise the multiply opcode.
module tb_execution_block;

   logic       Clk3 = 1'b0;
   logic       Rst_n;
   logic [7:0] A, B, data_in;
   logic [4:0] Op_ex;
   logic       Mem_en_dec, Mem_rw_dec, Mem_mux_sel_dec;
   logic [4:0] Rw_dec;
   logic [7:0] ans_ex;
   logic [3:0] Flag;
   logic [7:0] Data_out, B_bypass;
   logic       Mem_en_ex, Mem_rw_ex, Mem_mux_sel_ex;
   logic [4:0] Rw_ex;

   execution_block dut (
      .Clk3            (Clk3),
      .Rst_n           (Rst_n),
      .A               (A),
      .B               (B),
      .data_in         (data_in),
      .Op_ex           (Op_ex),
      .Mem_en_dec      (Mem_en_dec),
      .Mem_rw_dec      (Mem_rw_dec),
      .Mem_mux_sel_dec (Mem_mux_sel_dec),
      .Rw_dec          (Rw_dec),
      .ans_ex          (ans_ex),
      .Flag            (Flag),
      .Data_out        (Data_out),
      .B_bypass        (B_bypass),
      .Mem_en_ex       (Mem_en_ex),
      .Mem_rw_ex       (Mem_rw_ex),
      .Mem_mux_sel_ex  (Mem_mux_sel_ex),
      .Rw_ex           (Rw_ex)
   );

   always #5 Clk3 = ~Clk3;

   typedef struct {
      logic [4:0] op;
      logic [7:0] a, b, d;
      logic [2:0] mem;   // {en, rw, sel}
      logic [4:0] rw;
      logic [7:0] ans;
      logic [3:0] fl;    // {C,Z,N,V}
   } vec_t;

   vec_t       tbl[$];
   int         total = 0;
   int         bad   = 0;
   int         m_ans;
   logic [3:0] m_fl;

   function automatic vec_t mk(input logic [4:0] op, input logic [7:0] a, b, d,
                               input logic [2:0] mem, input logic [4:0] rw,
                               input logic [7:0] ans, input logic [3:0] fl);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.d = d; v.mem = mem; v.rw = rw; v.ans = ans; v.fl = fl;
      return v;
   endfunction

   function automatic int sx(input int x);
      return (x > 127) ? x - 256 : x;
   endfunction

   function automatic bit sovf(input int s);
      return (s < -128) || (s > 127);
   endfunction

   // Reference model: plain integer arithmetic, bit-at-a-time shifting.
   function automatic void ref_step(input logic [4:0] op, input int a, input int b, input int d,
                                    inout int ans, inout logic [3:0] fl);
      int r;
      int cin;
      int n;
      bit cf, vf, ua, uf;
      r = 0; cf = 0; vf = 0; ua = 1; uf = 1;
      cin = fl[3] ? 1 : 0;
      n = b % 8;
      case (int'(op))
         0:  begin r = a + b;       cf = r > 255; vf = sovf(sx(a) + sx(b)); end
         1:  begin r = a + b + cin; cf = r > 255; vf = sovf(sx(a) + sx(b) + cin); end
         2:  begin r = a - b;       cf = r < 0;   vf = sovf(sx(a) - sx(b)); end
         3:  begin r = a - b - cin; cf = r < 0;   vf = sovf(sx(a) - sx(b) - cin); end
         4:  r = a & b;
         5:  r = a | b;
         6:  r = a ^ b;
         7:  r = 255 - a;
         8:  begin r = -a;          cf = r < 0;   vf = sovf(-sx(a)); end
         9:  begin r = a - b;       cf = r < 0;   vf = sovf(sx(a) - sx(b)); ua = 0; end
         10: r = a;
         11: r = b;
         12: r = 255 - (a & b);
         13: r = 255 - (a | b);
         14: r = 255 - (a ^ b);
         15: begin r = a + 1;       cf = r > 255; vf = sovf(sx(a) + 1); end
         16: begin r = a - 1;       cf = r < 0;   vf = sovf(sx(a) - 1); end
         17: r = 0;
         20: begin r = a; for (int i = 0; i < n; i++) begin cf = r >= 128; r = (r * 2) % 256; end end
         21: begin r = a; for (int i = 0; i < n; i++) begin cf = (r % 2) != 0; r = r / 2; end end
         22: begin r = a; for (int i = 0; i < n; i++) begin cf = r >= 128; r = (r * 2) % 256 + (cf ? 1 : 0); end end
         23: begin r = a; for (int i = 0; i < n; i++) begin cf = (r % 2) != 0; r = r / 2 + (cf ? 128 : 0); end end
         24: begin r = a; for (int i = 0; i < n; i++) begin cf = (r % 2) != 0; r = r / 2 + ((r >= 128) ? 128 : 0); end end
         25, 26: begin r = a + b; uf = 0; end
`ifdef EXEC_MUL_EN
         27: begin r = a * b; cf = r > 255; end
`endif
         28: r = d;
         29: r = (a % 16) * 16 + a / 16;
         default: begin ua = 0; uf = 0; end
      endcase
      r = ((r % 256) + 256) % 256;
      if (ua) ans = r;
      if (uf) fl = {cf, r == 0, r >= 128, vf};
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      Op_ex = v.op; A = v.a; B = v.b; data_in = v.d;
      {Mem_en_dec, Mem_rw_dec, Mem_mux_sel_dec} = v.mem;
      Rw_dec = v.rw;
   endtask

   task automatic chk_pass(input string tag, input vec_t v);
      chk({tag, " Data_out"}, int'(Data_out), int'(v.d));
      chk({tag, " B_bypass"}, int'(B_bypass), int'(v.b));
      chk({tag, " Mem_ex"}, int'({Mem_en_ex, Mem_rw_ex, Mem_mux_sel_ex}), int'(v.mem));
      chk({tag, " Rw_ex"}, int'(Rw_ex), int'(v.rw));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " ans_ex"}, int'(ans_ex), 0);
      chk({tag, " Flag"}, int'(Flag), 0);
      chk({tag, " passthru"}, int'({Data_out, B_bypass, Mem_en_ex, Mem_rw_ex, Mem_mux_sel_ex, Rw_ex}), 0);
   endtask

   initial begin
      vec_t v;
      // {op, a, b, d, mem, rw, exp ans, exp {C,Z,N,V}}
      tbl.push_back(mk(5'b01010, 8'h01, 8'h11, 8'h21, 3'b001, 5'd8,  8'h01, 4'b0000));
      tbl.push_back(mk(5'b01010, 8'h02, 8'h12, 8'h22, 3'b010, 5'd6,  8'h02, 4'b0000));
      tbl.push_back(mk(5'b01010, 8'h03, 8'h13, 8'h23, 3'b100, 5'd0,  8'h03, 4'b0000));
      tbl.push_back(mk(5'b01010, 8'h04, 8'h14, 8'h24, 3'b011, 5'd4,  8'h04, 4'b0000));
      tbl.push_back(mk(5'b00000, 8'h03, 8'h03, 8'h00, 3'b000, 5'd1,  8'h06, 4'b0000));
      tbl.push_back(mk(5'b00000, 8'hC0, 8'h40, 8'h00, 3'b000, 5'd2,  8'h00, 4'b1100));
      tbl.push_back(mk(5'b00010, 8'h40, 8'hC0, 8'h00, 3'b000, 5'd3,  8'h80, 4'b1011));
      tbl.push_back(mk(5'b01001, 8'h02, 8'h02, 8'h00, 3'b000, 5'd4,  8'h80, 4'b0100));
      tbl.push_back(mk(5'b11111, 8'h05, 8'h07, 8'h00, 3'b000, 5'd5,  8'h80, 4'b0100));
      tbl.push_back(mk(5'b10101, 8'h80, 8'h04, 8'h00, 3'b000, 5'd6,  8'h08, 4'b0000));
      tbl.push_back(mk(5'b10110, 8'hC0, 8'h01, 8'h00, 3'b000, 5'd7,  8'h81, 4'b1010));
      tbl.push_back(mk(5'b10001, 8'h33, 8'h44, 8'h00, 3'b000, 5'd8,  8'h00, 4'b0100));
      tbl.push_back(mk(5'b00000, 8'hFF, 8'h02, 8'h00, 3'b000, 5'd9,  8'h01, 4'b1000));
      tbl.push_back(mk(5'b00001, 8'h01, 8'h01, 8'h00, 3'b000, 5'd10, 8'h03, 4'b0000));
      tbl.push_back(mk(5'b00010, 8'h00, 8'h01, 8'h00, 3'b000, 5'd11, 8'hFF, 4'b1010));
      tbl.push_back(mk(5'b00011, 8'h05, 8'h02, 8'h00, 3'b000, 5'd12, 8'h02, 4'b0000));
      tbl.push_back(mk(5'b01000, 8'h80, 8'h00, 8'h00, 3'b000, 5'd13, 8'h80, 4'b1011));
      tbl.push_back(mk(5'b01111, 8'h7F, 8'h00, 8'h00, 3'b000, 5'd14, 8'h80, 4'b0011));
      tbl.push_back(mk(5'b10000, 8'h00, 8'h00, 8'h00, 3'b000, 5'd15, 8'hFF, 4'b1010));
      tbl.push_back(mk(5'b10100, 8'h81, 8'h01, 8'h00, 3'b000, 5'd16, 8'h02, 4'b1000));
      tbl.push_back(mk(5'b11000, 8'h80, 8'h03, 8'h00, 3'b000, 5'd17, 8'hF0, 4'b0010));
      tbl.push_back(mk(5'b10100, 8'h55, 8'h08, 8'h00, 3'b000, 5'd18, 8'h55, 4'b0000));
      tbl.push_back(mk(5'b10111, 8'h01, 8'h01, 8'h00, 3'b000, 5'd19, 8'h80, 4'b1010));
      tbl.push_back(mk(5'b11001, 8'h10, 8'h20, 8'h00, 3'b000, 5'd20, 8'h30, 4'b1010));
      tbl.push_back(mk(5'b11100, 8'hAA, 8'hBB, 8'h00, 3'b000, 5'd21, 8'h00, 4'b0100));
      tbl.push_back(mk(5'b11101, 8'h3C, 8'h00, 8'h00, 3'b000, 5'd22, 8'hC3, 4'b0010));
      tbl.push_back(mk(5'b00110, 8'hF0, 8'hFF, 8'h00, 3'b000, 5'd23, 8'h0F, 4'b0000));
      tbl.push_back(mk(5'b01100, 8'hFF, 8'hFF, 8'h00, 3'b000, 5'd24, 8'h00, 4'b0100));
      tbl.push_back(mk(5'b00111, 8'h00, 8'h00, 8'h00, 3'b000, 5'd25, 8'hFF, 4'b0010));
      tbl.push_back(mk(5'b01011, 8'h77, 8'h00, 8'h00, 3'b000, 5'd26, 8'h00, 4'b0100));
      tbl.push_back(mk(5'b01101, 8'h00, 8'h00, 8'h00, 3'b000, 5'd27, 8'hFF, 4'b0010));
      tbl.push_back(mk(5'b01110, 8'hAA, 8'h55, 8'h00, 3'b000, 5'd28, 8'h00, 4'b0100));
      tbl.push_back(mk(5'b10010, 8'h12, 8'h34, 8'h00, 3'b000, 5'd29, 8'h00, 4'b0100));
      tbl.push_back(mk(5'b00101, 8'h01, 8'h02, 8'h00, 3'b000, 5'd30, 8'h03, 4'b0000));
`ifdef EXEC_MUL_EN
      tbl.push_back(mk(5'b11011, 8'h10, 8'h10, 8'h00, 3'b000, 5'd31, 8'h00, 4'b1100));
      tbl.push_back(mk(5'b11010, 8'hC0, 8'h01, 8'h08, 3'b111, 5'd10, 8'hC1, 4'b1100));
`else
      tbl.push_back(mk(5'b11011, 8'h10, 8'h10, 8'h00, 3'b000, 5'd31, 8'h03, 4'b0000));
      tbl.push_back(mk(5'b11010, 8'hC0, 8'h01, 8'h08, 3'b111, 5'd10, 8'hC1, 4'b0000));
`endif

      // Power-on reset
      Rst_n = 1'b0;
      v = mk(5'b0, 8'h0, 8'h0, 8'h0, 3'b0, 5'd0, 8'h0, 4'h0);
      drive(v);
      #12;
      chk_zero("por");
      @(posedge Clk3); #1;
      Rst_n = 1'b1;
      m_ans = 0; m_fl = 4'h0;

      // Directed table
      foreach (tbl[i]) begin
         drive(tbl[i]);
         ref_step(tbl[i].op, int'(tbl[i].a), int'(tbl[i].b), int'(tbl[i].d), m_ans, m_fl);
         @(posedge Clk3); #1;
         chk($sformatf("vec%0d ans", i), int'(ans_ex), int'(tbl[i].ans));
         chk($sformatf("vec%0d flag", i), int'(Flag), int'(tbl[i].fl));
         chk_pass($sformatf("vec%0d", i), tbl[i]);
      end

      // Mid-cycle reset with nonzero outputs: clears at once, holds through an edge
      #3 Rst_n = 1'b0;
      #1 chk_zero("rst async");
      v = mk(5'b01010, 8'h5A, 8'h6B, 8'h7C, 3'b101, 5'd3, 8'h5A, 4'h0);
      drive(v);
      @(posedge Clk3); #1;
      chk_zero("rst held");
      Rst_n = 1'b1;
      #1 chk_zero("rst released");
      m_ans = 0; m_fl = 4'h0;
      ref_step(v.op, int'(v.a), int'(v.b), int'(v.d), m_ans, m_fl);
      @(posedge Clk3); #1;
      chk("post-rst ans", int'(ans_ex), m_ans);
      chk("post-rst flag", int'(Flag), int'(m_fl));
      chk_pass("post-rst", v);

      // Random ops against the reference model
      for (int k = 0; k < 600; k++) begin
         v.op  = 5'($urandom_range(0, 31));
         v.a   = 8'($urandom);
         v.b   = 8'($urandom);
         v.d   = 8'($urandom);
         v.mem = 3'($urandom);
         v.rw  = 5'($urandom);
         drive(v);
         ref_step(v.op, int'(v.a), int'(v.b), int'(v.d), m_ans, m_fl);
         @(posedge Clk3); #1;
         chk($sformatf("rnd%0d op%0d ans", k, v.op), int'(ans_ex), m_ans);
         chk($sformatf("rnd%0d op%0d flag", k, v.op), int'(Flag), int'(m_fl));
         chk_pass($sformatf("rnd%0d", k), v);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
